// File: rtl/serializer_scheduler_pkg.sv
// Shared types and constants for the round-robin serializer scheduler.
package ser_sched_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int SHIFT_NOMINAL = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serializer_scheduler_if.sv
// Requester and serializer signal bundle; the scheduler sits on the slave side.
interface serializer_scheduler_if
  import ser_sched_pkg::*;
#(
  parameter int N = 4
) ();

  localparam int ID_W = $clog2(N);

  logic [N-1:0]          req;
  logic [N*NIBBLE_W-1:0] req_data;
  logic [N-1:0]          ack;
  logic                  err;
  logic                  busy;
  logic [ID_W-1:0]       grant_id;
  logic                  tx_en;
  logic                  ser_load;
  logic [NIBBLE_W-1:0]   ser_data;
  logic                  ser_fn;
  logic [4:0]            ser_counter;

  modport master (
    output req, req_data, ser_fn, ser_counter,
    input  ack, err, busy, grant_id, tx_en, ser_load, ser_data
  );

  modport slave (
    input  req, req_data, ser_fn, ser_counter,
    output ack, err, busy, grant_id, tx_en, ser_load, ser_data
  );

endinterface

// File: rtl/serializer_scheduler_rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= N) ? (s - N) : s;
    return ID_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    gnt_id    = ptr;
    gnt_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      gnt_id    = req[wrap_add(ptr, k)] ? wrap_add(ptr, k) : gnt_id;
      gnt_valid = req[wrap_add(ptr, k)] ? 1'b1 : gnt_valid;
    end
  end

endmodule

// File: rtl/serializer_scheduler.sv
// Shares one 4-bit parallel-load serializer among N requesters, granting round-robin
// and acknowledging each frame once the serializer reports completion or times out.
module serializer_scheduler
  import ser_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input logic                   clk,
  input logic                   reset,
  serializer_scheduler_if.slave bus
);

  localparam int ID_W = $clog2(N);
  localparam int SC_W = $clog2(TIMEOUT) + 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [NIBBLE_W-1:0]   nib_q, nib_d;
  logic [SC_W-1:0]       scnt_q, scnt_d;
  logic                  to_flag_q, to_flag_d;
  logic                  ser_load_q, ser_load_d;
  logic [N-1:0]          ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [ID_W-1:0]       arb_id_s;
  logic                  arb_valid_s;
  logic [NIBBLE_W-1:0]   arb_nib_s;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] nxt;
    if (id == ID_W'(N - 1)) begin
      nxt = '0;
    end else begin
      nxt = id + ID_W'(1);
    end
    return nxt;
  endfunction

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.req),
    .ptr       (ptr_q),
    .gnt_id    (arb_id_s),
    .gnt_valid (arb_valid_s)
  );

  // Nibble of the arbitration winner, selected with constant slices.
  always_comb begin
    arb_nib_s = '0;
    for (int i = 0; i < N; i++) begin
      arb_nib_s = (arb_id_s == ID_W'(i)) ? bus.req_data[i*NIBBLE_W +: NIBBLE_W] : arb_nib_s;
    end
  end

  // Next-state logic plus next values of the registered Moore outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    nib_d      = nib_q;
    scnt_d     = scnt_q;
    to_flag_d  = to_flag_q;
    ack_d      = '0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d    = LOAD;
          grant_id_d = arb_id_s;
          nib_d      = arb_nib_s;
        end else begin
          state_d    = IDLE;
        end
      end
      LOAD: begin
        state_d   = SHIFT;
        scnt_d    = '0;
        to_flag_d = 1'b0;
      end
      SHIFT: begin
        scnt_d = scnt_q + SC_W'(1);
        // A finished serializer wins over a coincident timeout.
        if (bus.ser_fn) begin
          state_d = DONE;
        end else if (scnt_q == SC_LAST) begin
          state_d   = DONE;
          to_flag_d = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = next_id(grant_id_q);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ser_load_d = (state_d != SHIFT);
    busy_d     = (state_d != IDLE);
    if (state_d == DONE) begin
      ack_d[grant_id_d] = 1'b1;
      err_d             = to_flag_d;
    end else begin
      ack_d = '0;
      err_d = 1'b0;
    end
  end

  // State, capture and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      nib_q      <= '0;
      scnt_q     <= '0;
      to_flag_q  <= 1'b0;
      ser_load_q <= 1'b1;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      nib_q      <= nib_d;
      scnt_q     <= scnt_d;
      to_flag_q  <= to_flag_d;
      ser_load_q <= ser_load_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.ser_load = ser_load_q;
  assign bus.ser_data = nib_q;
  // tx carries data only while counter shows 1..4 during SHIFT.
  assign bus.tx_en    = (state_q == SHIFT) && (bus.ser_counter >= 5'd1) && (bus.ser_counter <= 5'd4);

endmodule
